// File: rtl/seq_divider16_pkg.sv
// ----------------------------------------------------------------------------
// seq_divider16_pkg
//   Shared definitions for the sequential divider:
//     - state_t        : FSM state encoding (IDLE / RUN / FIN)
//     - DIV_BY_ZERO_Q  : quotient pattern reported for a zero divisor (all ones);
//                        wide enough to be sliced down to any operand width <= 32
// ----------------------------------------------------------------------------
package seq_divider16_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage : seq_divider16_pkg

// File: rtl/seq_divider16_subtractor17bit.sv
// ----------------------------------------------------------------------------
// subtractor17bit
//   Combinational unsigned subtractor, the subtract counterpart of the
//   datapath adder. Also reused by the comparator.
// Ports
//   aIn     in   WIDTH  minuend
//   bIn     in   WIDTH  subtrahend
//   out     out  WIDTH  aIn - bIn (modulo 2**WIDTH)
//   borrow  out  1      1 when aIn < bIn (result would be negative)
// ----------------------------------------------------------------------------
module subtractor17bit #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    // One extra bit on both operands: its value after the subtraction is the
    // borrow out of the top bit.
    assign {borrow, out} = {1'b0, aIn} - {1'b0, bIn};

endmodule : subtractor17bit

// File: rtl/seq_divider16.sv
// ----------------------------------------------------------------------------
// seq_divider16
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   The caller pulses start with two operands, stalls while busy=1 and
//   captures quotient/remainder when done=1.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for start; operands latched on the accepted edge
//   RUN    | one shift-and-subtract iteration per clock, WIDTH iterations
//   FIN    | done=1 for one cycle, results valid; returns to IDLE
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high reset
//   start        in   1      request, honoured only in IDLE
//   dividendIn   in   WIDTH  unsigned dividend
//   divisorIn    in   WIDTH  unsigned divisor
//   busy         out  1      high while iterating
//   done         out  1      single-cycle completion pulse
//   quotient     out  WIDTH  result, held until the next completion
//   remainder    out  WIDTH  result, held until the next completion
//   divByZero    out  1      divisor was zero; held like the results
// ----------------------------------------------------------------------------
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendIn,
    input  logic [WIDTH-1:0] divisorIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q;
    logic [WIDTH-1:0]  div_q;        // latched divisor
    logic [WIDTH-1:0]  dvd_q;        // dividend shifts out the top, quotient bits enter the bottom
    logic [WIDTH-1:0]  rem_q;        // partial remainder
    logic [WIDTH-1:0]  quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              dbz_q;

    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;
    logic              trial_borrow;
    logic [WIDTH:0]    kept;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  dvd_next;
    logic              last_iter;
    logic              div_is_zero;
    logic              unused_msb;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    subtractor17bit #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .aIn    (shifted),
        .bIn    ({1'b0, div_q}),
        .out    (trial),
        .borrow (trial_borrow)
    );

    // Restoring step: keep the shifted value when the subtraction would go
    // negative. Since rem_q < div_q, the selected value is always < div_q,
    // so its top bit is zero and only the low WIDTH bits are stored.
    assign kept       = trial_borrow ? shifted : trial;
    assign rem_next   = kept[WIDTH-1:0];
    assign dvd_next   = {dvd_q[WIDTH-2:0], ~trial_borrow};
    assign last_iter  = (count_q == LAST_ITER);
    assign div_is_zero = (divisorIn == '0);
    assign unused_msb = kept[WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = div_is_zero ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and result registers. Results are written on the
    // edge that enters FIN so they are already valid while done=1, and are
    // left alone during RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            div_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        div_q   <= divisorIn;
                        dvd_q   <= dividendIn;
                        rem_q   <= '0;
                        count_q <= '0;
                        if (div_is_zero) begin
                            quotient_q  <= DIV_BY_ZERO_Q[WIDTH-1:0];
                            remainder_q <= dividendIn;
                            dbz_q       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    rem_q   <= rem_next;
                    dvd_q   <= dvd_next;
                    count_q <= count_q + 1'b1;
                    if (last_iter) begin
                        quotient_q  <= dvd_next;
                        remainder_q <= rem_next;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign divByZero = dbz_q;

endmodule : seq_divider16

// File: tb/tb_seq_divider16.sv
module tb_seq_divider16;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividendIn;
    logic [15:0] divisorIn;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        divByZero;

    int checks   = 0;
    int failures = 0;

    // Result the DUT is expected to be holding between completions.
    logic [15:0] last_q   = 16'd0;
    logic [15:0] last_r   = 16'd0;
    logic        last_dbz = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
        int          repulse_at;
        bit          fin_start;
    } tv_t;

    tv_t vec[15];

    always #5 clk = ~clk;

    seq_divider16 dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividendIn (dividendIn),
        .divisorIn  (divisorIn),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .divByZero  (divByZero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one division and follows it to completion. repulse_at > 0 pulses
    // start with 8/2 at that cycle while busy; fin_start raises start during
    // the done cycle, which must also be ignored.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int elat, input int repulse_at, input bit fin_start);
        int cyc;
        @(negedge clk);
        start      = 1'b1;
        dividendIn = a;
        divisorIn  = b;
        @(negedge clk);
        start      = 1'b0;
        dividendIn = 16'($urandom);
        divisorIn  = 16'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc <= 40) begin
            chk({name, " busy"}, 32'(busy), 32'd1);
            chk({name, " hold_q"}, 32'(quotient), 32'(last_q));
            chk({name, " hold_r"}, 32'(remainder), 32'(last_r));
            if (cyc == repulse_at) begin
                start      = 1'b1;
                dividendIn = 16'd8;
                divisorIn  = 16'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " latency"}, 32'(cyc), 32'(elat));
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        chk({name, " q"}, 32'(quotient), 32'(eq));
        chk({name, " r"}, 32'(remainder), 32'(er));
        chk({name, " dbz"}, 32'(divByZero), 32'(edbz));
        last_q   = eq;
        last_r   = er;
        last_dbz = edbz;
        if (fin_start) begin
            start      = 1'b1;
            dividendIn = 16'd77;
            divisorIn  = 16'd5;
        end
        @(negedge clk);
        start = 1'b0;
        chk({name, " done_width"}, 32'(done), 32'd0);
        chk({name, " idle_after"}, 32'(busy), 32'd0);
        chk({name, " q_held"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        int seen;
        logic [15:0] ra, rb, rq, rr;

        vec[0]  = '{"100/7",      16'd100,   16'd7,     16'd14,    16'd2,   1'b0, 17, 0, 1'b0};
        vec[1]  = '{"ffff/1",     16'hFFFF,  16'd1,     16'hFFFF,  16'd0,   1'b0, 17, 0, 1'b0};
        vec[2]  = '{"3/10",       16'd3,     16'd10,    16'd0,     16'd3,   1'b0, 17, 0, 1'b0};
        vec[3]  = '{"5/0",        16'd5,     16'd0,     16'hFFFF,  16'd5,   1'b1, 1,  0, 1'b0};
        vec[4]  = '{"9/3",        16'd9,     16'd3,     16'd3,     16'd0,   1'b0, 17, 0, 1'b1};
        vec[5]  = '{"50/5_repul", 16'd50,    16'd5,     16'd10,    16'd0,   1'b0, 17, 4, 1'b0};
        vec[6]  = '{"0/5",        16'd0,     16'd5,     16'd0,     16'd0,   1'b0, 17, 0, 1'b0};
        vec[7]  = '{"ffff/ffff",  16'hFFFF,  16'hFFFF,  16'd1,     16'd0,   1'b0, 17, 0, 1'b0};
        vec[8]  = '{"ffff/256",   16'hFFFF,  16'd256,   16'd255,   16'd255, 1'b0, 17, 0, 1'b0};
        vec[9]  = '{"12345/123",  16'd12345, 16'd123,   16'd100,   16'd45,  1'b0, 17, 0, 1'b0};
        vec[10] = '{"40000/7",    16'd40000, 16'd7,     16'd5714,  16'd2,   1'b0, 17, 0, 1'b0};
        vec[11] = '{"1/ffff",     16'd1,     16'hFFFF,  16'd0,     16'd1,   1'b0, 17, 0, 1'b0};
        vec[12] = '{"0/0",        16'd0,     16'd0,     16'hFFFF,  16'd0,   1'b1, 1,  0, 1'b1};
        vec[13] = '{"7/7",        16'd7,     16'd7,     16'd1,     16'd0,   1'b0, 17, 0, 1'b0};
        vec[14] = '{"8000/2",     16'h8000,  16'd2,     16'h4000,  16'd0,   1'b0, 17, 0, 1'b0};

        // Reset with start asserted: reset must win.
        reset      = 1'b1;
        start      = 1'b1;
        dividendIn = 16'd100;
        divisorIn  = 16'd7;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset q", 32'(quotient), 32'd0);
        chk("reset r", 32'(remainder), 32'd0);
        chk("reset dbz", 32'(divByZero), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset idle", 32'(busy), 32'd0);

        for (int i = 0; i < 15; i++) begin
            run_op(vec[i].name, vec[i].a, vec[i].b, vec[i].q, vec[i].r, vec[i].dbz,
                   vec[i].lat, vec[i].repulse_at, vec[i].fin_start);
        end

        // Reset during RUN: abort, clear outputs, no done pulse afterwards.
        @(negedge clk);
        start      = 1'b1;
        dividendIn = 16'd1000;
        divisorIn  = 16'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort q", 32'(quotient), 32'd0);
        chk("abort r", 32'(remainder), 32'd0);
        chk("abort dbz", 32'(divByZero), 32'd0);
        last_q   = 16'd0;
        last_r   = 16'd0;
        last_dbz = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort no_activity", 32'(seen), 32'd0);
        run_op("1000/3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17, 0, 1'b0);

        // Random regression against a behavioural reference.
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(0, 15));
                1:       rb = 16'($urandom_range(0, 255));
                default: rb = 16'($urandom);
            endcase
            if (rb == 16'd0) begin
                rq = 16'hFFFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_op("random", ra, rb, rq, rr, (rb == 16'd0), (rb == 16'd0) ? 1 : 17, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_divider16
